dmux_pipeline_scheduler: RTL and testbench
==========================================

Name: dmux_pipeline_scheduler

Overview:
Issue controller for dmux_pipeline. It accepts a tagged stream (data + destination index) through a valid/ready handshake and drives the demux `sel` and `in` ports. It generates a per-output valid strobe aligned to the demux's fixed LATENCY. Per-output credit counters provide backpressure so no downstream consumer is overrun, and a drain state machine quiesces the pipeline for reconfiguration.

Parameters:
WIDTH, 8, data width; equals dmux_pipeline WIDTH.
OUTPUT_COUNT, 4, number of demux outputs; >= 2.
LATENCY, 2, latency of the attached dmux_pipeline in clocks; >= 0.
CREDITS, 2, initial and maximum credits per output; >= 1.
CREDIT_W, $clog2(CREDITS+1), width of each credit counter (localparam).
SEL_W, $clog2(OUTPUT_COUNT), width of the select (localparam).

Ports:
clk  in  1  system clock; all state is updated on the rising edge.
rst  in  1  asynchronous active-high reset.
enable  in  1  level; permits issue.
flush_req  in  1  pulse; requests a drain.
in_valid  in  1  input transfer valid.
in_ready  out  1  input transfer ready.
in_data  in  WIDTH  payload.
in_dest  in  SEL_W  destination output index.
dmux_sel  out  SEL_W  to dmux_pipeline `sel`; registered.
dmux_in  out  WIDTH  to dmux_pipeline `in`; registered.
out_valid  out  OUTPUT_COUNT  one-hot strobe; qualifies the demux outputs.
credit_return  in  OUTPUT_COUNT  per-output pulse from a consumer; returns one credit.
busy  out  1  high when in_flight != 0 or state != IDLE.
flush_done  out  1  one-cycle pulse.
err_dest  out  1  sticky; cleared only by rst.
err_credit  out  1  sticky; cleared only by rst.

Behaviour:
- Reset (async assert, sync deassert expected upstream) drives the following values:
  - state = IDLE; every credit counter = CREDITS; in_flight = 0.
  - dmux_sel = 0, dmux_in = 0, in_ready = 0, out_valid = 0, flush_done = 0, err_* = 0.
  - The valid/dest delay line is cleared.
- The FSM has three states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when enable = 1 and flush_req = 0.
  - RUN -> DRAIN when flush_req = 1 or enable = 0.
  - DRAIN -> IDLE when in_flight == 0. A one-cycle flush_done pulse is asserted on that transition.
  - flush_req while in IDLE produces a flush_done pulse on the next cycle.
  - flush_req while in DRAIN is ignored.
- in_ready:
  - in_ready = (state == RUN) && (in_dest >= OUTPUT_COUNT || credit[in_dest] != 0).
  - It is combinational on in_dest and must not depend on in_valid.
- Issue occurs when in_valid && in_ready are high at an edge, with in_dest < OUTPUT_COUNT:
  - dmux_sel <= in_dest and dmux_in <= in_data.
  - credit[in_dest] decrements.
  - A valid token with in_dest enters a delay line of depth LATENCY+1.
- No issue on a cycle:
  - dmux_in <= 0 and dmux_sel holds its previous value.
  - A null token enters the delay line.
- Invalid destination (in_dest >= OUTPUT_COUNT) with a handshake:
  - The transfer is consumed and dropped; err_dest is set.
  - No token is issued and no credit changes.
- Output timing: for a handshake at edge t, dmux_sel/dmux_in are valid from edge t+1. out_valid[in_dest] is high for exactly one cycle, starting at edge t+1+LATENCY.
  - With LATENCY = 0 this is the cycle after the handshake.
  - The bus sustains one issue per clock.
- Credits:
  - An issue and a credit_return on the same output in the same cycle leave the counter unchanged.
  - A credit_return on a counter already at CREDITS saturates the counter and sets err_credit.
  - Credits are returned independently of the FSM state, including during DRAIN and IDLE.
- in_flight counts tokens issued but whose out_valid has not yet fired; its range is 0..LATENCY+1. An issue and a retire in the same cycle leave it unchanged.
- Reset asserted mid-flight discards all in-flight tokens. No out_valid is produced for them afterwards.

Test Plan:
1. rst, then enable=1; send in_dest=2, in_data=0xA5 at edge 5 -> dmux_sel=2 and dmux_in=0xA5 at edge 6; out_valid=4'b0100 for one cycle at edge 8; credit[2] = 1.
2. Back-to-back sends to dest 0,1,2,3,0 with data 0x10..0x14 at edges 5..9 -> out_valid one-hot 0001, 0010, 0100, 1000, 0001 at edges 8..12; in_ready stays high throughout.
3. Three sends to dest 1 with no credit_return -> the third handshake is blocked because in_ready=0 for dest 1; in_ready=1 when dest 0 is presented; after a credit_return[1] pulse, the third dest-1 send completes.
4. Issue to dest 3 and credit_return[3] in the same cycle with credit[3]=1 -> credit[3] remains 1; a second credit_return[3] while at 2 -> counter stays 2 and err_credit=1.
5. Issue at edges 5 and 6, then flush_req at edge 6 -> in_ready=0 from edge 7; both out_valid strobes still appear (edges 8 and 9); flush_done pulses one cycle after the last in_flight decrement; state = IDLE.
6. With OUTPUT_COUNT=3, in_dest=3 -> handshake accepted, err_dest=1, no out_valid, credits unchanged. Separately, rst asserted at edge 7 after an issue at edge 6 -> all outputs zero immediately and no out_valid thereafter.

Source files
------------

// File: rtl/dmux_pipeline_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dmux_pipeline_scheduler_if
// Purpose  : Tagged input stream, demux issue bus, per-output valid strobes
//            and credit returns shared between the scheduler and its peers.
// Revision : 1.0 - initial release
// ============================================================================
interface dmux_pipeline_scheduler_if #(
   parameter int WIDTH        = 8,
   parameter int OUTPUT_COUNT = 4
);
   localparam int SEL_W = $clog2(OUTPUT_COUNT);

   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        in_data;
   logic [SEL_W-1:0]        in_dest;
   logic [SEL_W-1:0]        dmux_sel;
   logic [WIDTH-1:0]        dmux_in;
   logic [OUTPUT_COUNT-1:0] out_valid;
   logic [OUTPUT_COUNT-1:0] credit_return;

   // Producer / consumer side
   modport master (
      output in_valid, in_data, in_dest, credit_return,
      input  in_ready, dmux_sel, dmux_in, out_valid
   );

   // Scheduler side
   modport slave (
      input  in_valid, in_data, in_dest, credit_return,
      output in_ready, dmux_sel, dmux_in, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/dmux_pipeline_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dmux_pipeline_scheduler
// Purpose  : Issue controller for dmux_pipeline. Accepts a tagged stream,
//            drives the demux sel/in bus, strobes a one-hot out_valid aligned
//            to the demux latency and throttles issue with per-output credits.
// Revision : 1.0 - initial release
// ============================================================================
module dmux_pipeline_scheduler #(
   parameter int WIDTH        = 8,
   parameter int OUTPUT_COUNT = 4,
   parameter int LATENCY      = 2,
   parameter int CREDITS      = 2
) (
   input  wire                      clk,
   input  wire                      rst,
   input  wire                      enable_i,
   input  wire                      flush_req_i,
   output logic                     busy_o,
   output logic                     flush_done_o,
   output logic                     err_dest_o,
   output logic                     err_credit_o,
   dmux_pipeline_scheduler_if.slave bus
);
   localparam int SEL_W    = $clog2(OUTPUT_COUNT);
   localparam int CREDIT_W = $clog2(CREDITS + 1);
   localparam int FLIGHT_W = $clog2(LATENCY + 2);
   localparam logic [CREDIT_W-1:0] C_CREDIT_MAX = CREDIT_W'(CREDITS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                  state_q;
   logic                    flush_done_q;
   logic [SEL_W-1:0]        dmux_sel_q;
   logic [WIDTH-1:0]        dmux_in_q;
   logic [OUTPUT_COUNT-1:0] out_valid_q;
   logic [OUTPUT_COUNT-1:0] out_valid_d;
   logic [LATENCY:0]        tok_vld_q;
   logic [SEL_W-1:0]        tok_dest_q [LATENCY+1];
   logic [FLIGHT_W-1:0]     in_flight_q;
   logic                    err_dest_q;
   logic                    err_credit_q;
   logic [OUTPUT_COUNT-1:0] has_credit_w;
   logic [OUTPUT_COUNT-1:0] sat_hit_w;
   logic                    dest_ok_w;
   logic                    credit_ok_w;
   logic                    in_ready_w;
   logic                    issue_w;
   logic                    drop_w;
   logic                    retire_w;

   // Range-check the presented tag and look up its credit; independent of in_valid
   always_comb begin
      dest_ok_w   = (int'(bus.in_dest) < OUTPUT_COUNT);
      credit_ok_w = 1'b0;
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
         if (bus.in_dest == SEL_W'(i) && has_credit_w[i]) credit_ok_w = 1'b1;
      end
      // Out-of-range tags are always accepted so they can be dropped and flagged
      in_ready_w = (state_q == ST_RUN) && (!dest_ok_w || credit_ok_w);
      issue_w    = bus.in_valid && in_ready_w && dest_ok_w;
      drop_w     = bus.in_valid && in_ready_w && !dest_ok_w;
      retire_w   = tok_vld_q[LATENCY];
   end

   // Decode the token leaving the delay line into a one-hot strobe
   always_comb begin
      out_valid_d = '0;
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
         if (retire_w && tok_dest_q[LATENCY] == SEL_W'(i)) out_valid_d[i] = 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_credit
         logic [CREDIT_W-1:0] cnt_q;
         logic                take_w;
         logic                give_w;

         assign take_w           = issue_w && (bus.in_dest == SEL_W'(gi));
         assign give_w           = bus.credit_return[gi];
         assign has_credit_w[gi] = (cnt_q != '0);
         assign sat_hit_w[gi]    = give_w && !take_w && (cnt_q == C_CREDIT_MAX);

         // Per-output credit counter; a take and a give in one cycle cancel
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q <= C_CREDIT_MAX;
            end else if (take_w && !give_w) begin
               cnt_q <= cnt_q - CREDIT_W'(1);
            end else if (give_w && !take_w && cnt_q != C_CREDIT_MAX) begin
               cnt_q <= cnt_q + CREDIT_W'(1);
            end
         end
      end
   endgenerate

   // Run/drain sequencing; flush_done is a registered one-cycle pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         flush_done_q <= 1'b0;
      end else begin
         flush_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (flush_req_i) flush_done_q <= 1'b1;
               else if (enable_i) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (flush_req_i || !enable_i) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (in_flight_q == '0) begin
                  state_q      <= ST_IDLE;
                  flush_done_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Issue bus, token delay line, aligned out_valid, in-flight count and error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmux_sel_q   <= '0;
         dmux_in_q    <= '0;
         out_valid_q  <= '0;
         tok_vld_q    <= '0;
         in_flight_q  <= '0;
         err_dest_q   <= 1'b0;
         err_credit_q <= 1'b0;
         for (int k = 0; k <= LATENCY; k++) tok_dest_q[k] <= '0;
      end else begin
         if (issue_w) begin
            dmux_sel_q <= bus.in_dest;
            dmux_in_q  <= bus.in_data;
         end else begin
            dmux_in_q  <= '0;
         end
         tok_vld_q[0]  <= issue_w;
         tok_dest_q[0] <= issue_w ? bus.in_dest : '0;
         for (int k = 1; k <= LATENCY; k++) begin
            tok_vld_q[k]  <= tok_vld_q[k-1];
            tok_dest_q[k] <= tok_dest_q[k-1];
         end
         out_valid_q <= out_valid_d;
         if (issue_w && !retire_w)      in_flight_q <= in_flight_q + FLIGHT_W'(1);
         else if (!issue_w && retire_w) in_flight_q <= in_flight_q - FLIGHT_W'(1);
         if (drop_w)       err_dest_q   <= 1'b1;
         if (|sat_hit_w)   err_credit_q <= 1'b1;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.dmux_sel  = dmux_sel_q;
   assign bus.dmux_in   = dmux_in_q;
   assign bus.out_valid = out_valid_q;
   assign busy_o        = (in_flight_q != '0) || (state_q != ST_IDLE);
   assign flush_done_o  = flush_done_q;
   assign err_dest_o    = err_dest_q;
   assign err_credit_o  = err_credit_q;

endmodule
`default_nettype wire

// File: tb/tb_dmux_pipeline_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmux_pipeline_scheduler
// Purpose  : Self-checking bench for dmux_pipeline_scheduler: directed vector
//            table, hand-written corner sequences and randomized traffic
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmux_pipeline_scheduler;
   localparam int N   = 4;
   localparam int L   = 2;
   localparam int CR  = 2;
   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_DRAIN = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0, flush_req = 1'b0;
   logic busy, flush_done, err_dest, err_credit;
   logic en3 = 1'b0, fl3 = 1'b0;
   logic busy3, fd3, ed3, ec3;

   dmux_pipeline_scheduler_if #(.WIDTH(8), .OUTPUT_COUNT(N)) ifm ();
   dmux_pipeline_scheduler_if #(.WIDTH(8), .OUTPUT_COUNT(3)) ifm3 ();

   dmux_pipeline_scheduler #(.WIDTH(8), .OUTPUT_COUNT(N), .LATENCY(L), .CREDITS(CR)) dut (
      .clk(clk), .rst(rst), .enable_i(enable), .flush_req_i(flush_req),
      .busy_o(busy), .flush_done_o(flush_done), .err_dest_o(err_dest),
      .err_credit_o(err_credit), .bus(ifm)
   );

   dmux_pipeline_scheduler #(.WIDTH(8), .OUTPUT_COUNT(3), .LATENCY(L), .CREDITS(CR)) dut3 (
      .clk(clk), .rst(rst), .enable_i(en3), .flush_req_i(fl3),
      .busy_o(busy3), .flush_done_o(fd3), .err_dest_o(ed3),
      .err_credit_o(ec3), .bus(ifm3)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   logic last_ready;

   // ---------------- reference model ----------------
   typedef struct { int due; int dest; } tok_t;
   tok_t pend[$];
   int   m_state;
   int   m_credit [N];
   int   m_cyc = 0;
   logic m_err_c, m_err_d;
   logic [1:0] exp_sel;
   logic [7:0] exp_din;
   logic [3:0] exp_ov;
   logic       exp_fd, exp_busy;

   typedef struct {
      logic       vld;
      logic [1:0] dest;
      logic [7:0] data;
      logic       rdy;
      logic [1:0] sel;
      logic [7:0] din;
      logic [3:0] ov;
   } vec_t;
   vec_t vt [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE;
      for (int i = 0; i < N; i++) m_credit[i] = CR;
      pend.delete();
      m_err_c = 1'b0; m_err_d = 1'b0;
      exp_sel = '0; exp_din = '0; exp_ov = '0; exp_fd = 1'b0; exp_busy = 1'b0;
   endtask

   // Advance the model across one rising edge, given the inputs seen before it
   task automatic model_edge(input logic en, input logic fl, input logic hs,
                             input logic [1:0] dest, input logic [7:0] data,
                             input logic [3:0] cret);
      int   e;
      int   infl;
      tok_t keep[$];
      logic dec;
      e    = m_cyc + 1;
      infl = pend.size();
      exp_fd = 1'b0;
      case (m_state)
         S_IDLE:  if (fl) exp_fd = 1'b1; else if (en) m_state = S_RUN;
         S_RUN:   if (fl || !en) m_state = S_DRAIN;
         default: if (infl == 0) begin m_state = S_IDLE; exp_fd = 1'b1; end
      endcase
      for (int i = 0; i < N; i++) begin
         dec = hs && (int'(dest) == i);
         if (cret[i] && !dec) begin
            if (m_credit[i] == CR) m_err_c = 1'b1;
            else m_credit[i]++;
         end else if (dec && !cret[i]) begin
            m_credit[i]--;
         end
      end
      exp_ov = '0;
      keep = {};
      foreach (pend[k]) begin
         if (pend[k].due == e) exp_ov[pend[k].dest] = 1'b1;
         else keep.push_back(pend[k]);
      end
      pend = keep;
      if (hs) begin
         pend.push_back('{due: e + 1 + L, dest: int'(dest)});
         exp_sel = dest;
         exp_din = data;
      end else begin
         exp_din = '0;
      end
      exp_busy = (pend.size() != 0) || (m_state != S_IDLE);
      m_cyc = e;
   endtask

   // One clock: apply inputs, check in_ready, step model, check registered outputs
   task automatic step(input logic en, input logic fl, input logic vld, input logic [1:0] dest,
                       input logic [7:0] data, input logic [3:0] cret);
      logic mr;
      enable = en; flush_req = fl;
      ifm.in_valid = vld; ifm.in_dest = dest; ifm.in_data = data; ifm.credit_return = cret;
      #1;
      mr = (m_state == S_RUN) && (m_credit[dest] > 0);
      last_ready = ifm.in_ready;
      chk("in_ready", 32'(ifm.in_ready), 32'(mr));
      model_edge(en, fl, vld && mr, dest, data, cret);
      @(posedge clk); #1;
      chk("dmux_sel",   32'(ifm.dmux_sel),  32'(exp_sel));
      chk("dmux_in",    32'(ifm.dmux_in),   32'(exp_din));
      chk("out_valid",  32'(ifm.out_valid), 32'(exp_ov));
      chk("busy",       32'(busy),          32'(exp_busy));
      chk("flush_done", 32'(flush_done),    32'(exp_fd));
      chk("err_dest",   32'(err_dest),      32'(m_err_d));
      chk("err_credit", 32'(err_credit),    32'(m_err_c));
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; flush_req = 1'b0;
      ifm.in_valid = 1'b0; ifm.in_dest = '0; ifm.in_data = '0; ifm.credit_return = '0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("rst_dmux_sel",   32'(ifm.dmux_sel),  32'd0);
      chk("rst_dmux_in",    32'(ifm.dmux_in),   32'd0);
      chk("rst_in_ready",   32'(ifm.in_ready),  32'd0);
      chk("rst_out_valid",  32'(ifm.out_valid), 32'd0);
      chk("rst_flush_done", 32'(flush_done),    32'd0);
      chk("rst_busy",       32'(busy),          32'd0);
      chk("rst_errs",       32'({err_dest, err_credit}), 32'd0);
   endtask

   function automatic vec_t mk(input logic vld, input logic [1:0] d, input logic [7:0] dat,
                               input logic rdy, input logic [1:0] sel, input logic [7:0] din,
                               input logic [3:0] ov);
      vec_t v;
      v.vld = vld; v.dest = d; v.data = dat; v.rdy = rdy; v.sel = sel; v.din = din; v.ov = ov;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0] ov_acc;
      logic [2:0] ov3_acc;
      ifm3.in_valid = 1'b0; ifm3.in_dest = '0; ifm3.in_data = '0; ifm3.credit_return = '0;
      model_reset();
      do_reset();

      // single send to dest 2, then back-to-back sends to 0,1,2,3,0
      vt[0]  = mk(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 4'b0000);
      vt[1]  = mk(1'b1, 2'd2, 8'hA5, 1'b1, 2'd2, 8'hA5, 4'b0000);
      vt[2]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h00, 4'b0000);
      vt[3]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h00, 4'b0000);
      vt[4]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h00, 4'b0100);
      vt[5]  = mk(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h00, 4'b0000);
      vt[6]  = mk(1'b1, 2'd0, 8'h10, 1'b1, 2'd0, 8'h10, 4'b0000);
      vt[7]  = mk(1'b1, 2'd1, 8'h11, 1'b1, 2'd1, 8'h11, 4'b0000);
      vt[8]  = mk(1'b1, 2'd2, 8'h12, 1'b1, 2'd2, 8'h12, 4'b0000);
      vt[9]  = mk(1'b1, 2'd3, 8'h13, 1'b1, 2'd3, 8'h13, 4'b0001);
      vt[10] = mk(1'b1, 2'd0, 8'h14, 1'b1, 2'd0, 8'h14, 4'b0010);
      vt[11] = mk(1'b0, 2'd1, 8'h00, 1'b1, 2'd0, 8'h00, 4'b0100);
      vt[12] = mk(1'b0, 2'd1, 8'h00, 1'b1, 2'd0, 8'h00, 4'b1000);
      vt[13] = mk(1'b0, 2'd1, 8'h00, 1'b1, 2'd0, 8'h00, 4'b0001);
      vt[14] = mk(1'b0, 2'd2, 8'h00, 1'b0, 2'd0, 8'h00, 4'b0000);
      vt[15] = mk(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 4'b0000);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, vt[i].vld, vt[i].dest, vt[i].data, 4'b0000);
         chk($sformatf("vec%0d_ready", i), 32'(last_ready),     32'(vt[i].rdy));
         chk($sformatf("vec%0d_sel", i),   32'(ifm.dmux_sel),   32'(vt[i].sel));
         chk($sformatf("vec%0d_din", i),   32'(ifm.dmux_in),    32'(vt[i].din));
         chk($sformatf("vec%0d_ov", i),    32'(ifm.out_valid),  32'(vt[i].ov));
      end
      step(1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 4'b1111);
      step(1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 4'b0101);

      // credit exhaustion on dest 1, other dest still ready, resume after a return
      step(1'b1, 1'b0, 1'b1, 2'd1, 8'h21, 4'b0000); chk("t3_first",   32'(last_ready), 32'd1);
      step(1'b1, 1'b0, 1'b1, 2'd1, 8'h22, 4'b0000); chk("t3_second",  32'(last_ready), 32'd1);
      step(1'b1, 1'b0, 1'b1, 2'd1, 8'h23, 4'b0000); chk("t3_blocked", 32'(last_ready), 32'd0);
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000); chk("t3_dest0",   32'(last_ready), 32'd1);
      step(1'b1, 1'b0, 1'b1, 2'd1, 8'h23, 4'b0010); chk("t3_ret_cyc", 32'(last_ready), 32'd0);
      step(1'b1, 1'b0, 1'b1, 2'd1, 8'h23, 4'b0000); chk("t3_resume",  32'(last_ready), 32'd1);
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0010);
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0010);

      // simultaneous issue+return, then saturating return on dest 3
      step(1'b1, 1'b0, 1'b1, 2'd3, 8'h33, 4'b0000);
      step(1'b1, 1'b0, 1'b1, 2'd3, 8'h34, 4'b1000); chk("t4_cancel_rdy", 32'(last_ready), 32'd1);
      step(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 4'b1000); chk("t4_no_err", 32'(err_credit), 32'd0);
      step(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 4'b1000); chk("t4_err",    32'(err_credit), 32'd1);
      step(1'b1, 1'b0, 1'b1, 2'd3, 8'h35, 4'b0000); chk("t4_sat_a",  32'(last_ready), 32'd1);
      step(1'b1, 1'b0, 1'b1, 2'd3, 8'h36, 4'b0000); chk("t4_sat_b",  32'(last_ready), 32'd1);
      step(1'b1, 1'b0, 1'b1, 2'd3, 8'h37, 4'b0000); chk("t4_sat_c",  32'(last_ready), 32'd0);
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b1000);
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b1000);

      // drain with tokens in flight, then a flush request while idle
      step(1'b1, 1'b0, 1'b1, 2'd0, 8'h50, 4'b0000);
      step(1'b1, 1'b1, 1'b1, 2'd1, 8'h51, 4'b0000);
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
      chk("t5_ready_low", 32'(last_ready), 32'd0);
      chk("t5_ov_none",   32'(ifm.out_valid), 32'd0);
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000); chk("t5_ov_a", 32'(ifm.out_valid), 32'b0001);
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000); chk("t5_ov_b", 32'(ifm.out_valid), 32'b0010);
      chk("t5_fd_early", 32'(flush_done), 32'd0);
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
      chk("t5_flush_done", 32'(flush_done), 32'd1);
      chk("t5_idle",       32'(busy),       32'd0);
      step(1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000); chk("t5_idle_flush", 32'(flush_done), 32'd1);
      step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000); chk("t5_fd_clear",   32'(flush_done), 32'd0);

      // randomized traffic against the reference model
      for (int r = 0; r < 400; r++) begin
         step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 1'($urandom),
              2'($urandom), 8'($urandom), 4'($urandom & $urandom));
      end

      // reset asserted while a token is in flight
      do_reset();
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
      step(1'b1, 1'b0, 1'b1, 2'd1, 8'hC3, 4'b0000);
      rst = 1'b1;
      #1;
      chk("mid_rst_sel",   32'(ifm.dmux_sel),  32'd0);
      chk("mid_rst_din",   32'(ifm.dmux_in),   32'd0);
      chk("mid_rst_ov",    32'(ifm.out_valid), 32'd0);
      chk("mid_rst_busy",  32'(busy),          32'd0);
      chk("mid_rst_ready", 32'(ifm.in_ready),  32'd0);
      model_reset();
      enable = 1'b0; ifm.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      ov_acc = '0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
         ov_acc = ov_acc | ifm.out_valid;
      end
      chk("mid_rst_no_ov", 32'(ov_acc), 32'd0);

      // three-output instance: out-of-range destination
      en3 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("n3_err_dest_init", 32'(ed3), 32'd0);
      ifm3.in_valid = 1'b1; ifm3.in_dest = 2'd3; ifm3.in_data = 8'h5A;
      #1;
      chk("n3_ready_bad_dest", 32'(ifm3.in_ready), 32'd1);
      @(posedge clk); #1;
      ifm3.in_valid = 1'b0;
      chk("n3_err_dest", 32'(ed3),          32'd1);
      chk("n3_dmux_in",  32'(ifm3.dmux_in), 32'd0);
      ov3_acc = '0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         ov3_acc = ov3_acc | ifm3.out_valid;
      end
      chk("n3_no_out_valid", 32'(ov3_acc), 32'd0);
      ifm3.in_dest = 2'd2; ifm3.in_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk($sformatf("n3_credit%0d", j), 32'(ifm3.in_ready), 32'(j < 2));
         @(posedge clk); #1;
      end
      ifm3.in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
